// File: rtl/unified_program_mem.sv
// Shared instruction/data RAM: stallable fetch port plus a pipelined load/store port with sub-word alignment.
// Latency: READ_LATENCY (1 or 2) cycles from accepting edge to data on both ports; stores complete at the accepting edge.
// Backpressure: imem_stall_in freezes the fetch pipe; the data port never stalls. UNIFIED_PROGRAM_MEM_FAULT_EN adds dmem_fault_out.
module unified_program_mem #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          DEPTH_WORDS  = 16384,
    parameter logic [31:0] BASE_ADDR    = 32'h0002_0000,
    parameter logic [31:0] WINDOW_MASK  = 32'h000F_0000,
    parameter int          READ_LATENCY = 1,
    parameter string       INIT_FILE    = ""
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  imem_req_in,
    input  logic [ADDR_WIDTH-1:0] imem_addr_in,
    input  logic                  imem_stall_in,
    output logic                  imem_valid_out,
    output logic [31:0]           imem_data_out,
    input  logic                  dmem_req_in,
    input  logic                  dmem_we_in,
    input  logic [1:0]            dmem_size_in,
    input  logic                  dmem_unsigned_in,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_in,
    input  logic [31:0]           dmem_wdata_in,
    output logic                  dmem_rvalid_out,
    output logic [31:0]           dmem_rdata_out
`ifdef UNIFIED_PROGRAM_MEM_FAULT_EN
    ,
    output logic                  dmem_fault_out
`endif
);

    localparam int                    IDX_W  = $clog2(DEPTH_WORDS);
    localparam int                    LAST   = READ_LATENCY - 1;
    localparam logic [ADDR_WIDTH-1:0] MASK_A = ADDR_WIDTH'(WINDOW_MASK);
    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR & WINDOW_MASK);
    localparam logic [31:0]           NOP    = 32'h0000_0013;

    if ((READ_LATENCY != 1 && READ_LATENCY != 2) || (DEPTH_WORDS != (1 << IDX_W))) begin : g_bad_param
        $error("unified_program_mem: READ_LATENCY must be 1 or 2 and DEPTH_WORDS a power of 2");
    end

    typedef struct packed {
        logic       vld;
        logic       ok;
        logic [1:0] off;
        logic [1:0] size;
        logic       uns;
    } ld_ctl_t;

    // Contents are intentionally never reset; INIT_FILE names the preload image for the memory build flow.
    logic [31:0] mem [DEPTH_WORDS];

    // ---------------- fetch port ----------------
    logic [IDX_W-1:0] i_idx;
    logic             i_win;
    logic             f_vld [READ_LATENCY];
    logic [31:0]      f_dat [READ_LATENCY];

    assign i_idx = imem_addr_in[IDX_W+1:2];
    assign i_win = (imem_addr_in & MASK_A) == BASE_A;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < READ_LATENCY; s++) begin
                f_vld[s] <= 1'b0;
                f_dat[s] <= '0;
            end
        end else if (!imem_stall_in) begin
            f_vld[0] <= imem_req_in;
            if (imem_req_in)
                f_dat[0] <= i_win ? mem[i_idx] : NOP;
            for (int s = 1; s < READ_LATENCY; s++) begin
                f_vld[s] <= f_vld[s-1];
                f_dat[s] <= f_dat[s-1];
            end
        end
    end

    assign imem_valid_out = f_vld[LAST];
    assign imem_data_out  = f_dat[LAST];

    // ---------------- data port: request decode ----------------
    logic [IDX_W-1:0] d_idx;
    logic [1:0]       d_off;
    logic             d_win;
    logic             d_mis;
    logic             d_wr;
    logic             d_rd;
    logic [3:0]       d_be;
    logic [31:0]      d_wdat;
    ld_ctl_t          d_req_ctl;

    assign d_idx = dmem_addr_in[IDX_W+1:2];
    assign d_off = dmem_addr_in[1:0];
    assign d_win = (dmem_addr_in & MASK_A) == BASE_A;

    always_comb begin
        d_mis  = 1'b0;
        d_be   = 4'hF;
        d_wdat = dmem_wdata_in;
        case (dmem_size_in)
            2'd0: begin
                d_be   = 4'b0001 << d_off;
                d_wdat = {4{dmem_wdata_in[7:0]}};
            end
            2'd1: begin
                d_mis  = d_off[0];
                d_be   = 4'b0011 << d_off;
                d_wdat = {2{dmem_wdata_in[15:0]}};
            end
            default: d_mis = (d_off != 2'b00);
        endcase
    end

    assign d_wr = dmem_req_in & dmem_we_in & d_win & ~d_mis;
    assign d_rd = dmem_req_in & ~dmem_we_in;

    always_comb begin
        d_req_ctl      = '0;
        d_req_ctl.vld  = d_rd;
        d_req_ctl.ok   = d_win & ~d_mis;
        d_req_ctl.off  = d_off;
        d_req_ctl.size = dmem_size_in;
        d_req_ctl.uns  = dmem_unsigned_in;
    end

    // Writes are gated by reset so requests presented during reset are ignored.
    always_ff @(posedge clk_in) begin
        if (rst_n_in && d_wr) begin
            for (int b = 0; b < 4; b++)
                if (d_be[b])
                    mem[d_idx][8*b +: 8] <= d_wdat[8*b +: 8];
        end
    end

    // ---------------- data port: load pipeline ----------------
    ld_ctl_t     d_ctl  [READ_LATENCY];
    logic [31:0] d_word [READ_LATENCY];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < READ_LATENCY; s++)
                d_ctl[s] <= '0;
        end else begin
            d_ctl[0] <= d_req_ctl;
            for (int s = 1; s < READ_LATENCY; s++)
                d_ctl[s] <= d_ctl[s-1];
        end
    end

    // Raw word needs no reset: it is only observed when the matching control stage is valid.
    always_ff @(posedge clk_in) begin
        if (d_rd)
            d_word[0] <= mem[d_idx];
        for (int s = 1; s < READ_LATENCY; s++)
            d_word[s] <= d_word[s-1];
    end

    ld_ctl_t     ld;
    logic [31:0] ld_word;
    logic [15:0] lane;
    logic [31:0] fmt;

    assign ld      = d_ctl[LAST];
    assign ld_word = d_word[LAST];

    always_comb begin
        lane = 16'(ld_word >> {ld.off, 3'b000});
        case (ld.size)
            2'd0:    fmt = ld.uns ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'd1:    fmt = ld.uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: fmt = ld_word;
        endcase
    end

    assign dmem_rvalid_out = ld.vld;
    assign dmem_rdata_out  = (ld.vld && ld.ok) ? fmt : '0;

`ifdef UNIFIED_PROGRAM_MEM_FAULT_EN
    logic d_flt [READ_LATENCY];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < READ_LATENCY; s++)
                d_flt[s] <= 1'b0;
        end else begin
            d_flt[0] <= dmem_req_in & ~(d_win & ~d_mis);
            for (int s = 1; s < READ_LATENCY; s++)
                d_flt[s] <= d_flt[s-1];
        end
    end

    assign dmem_fault_out = d_flt[LAST];
`endif

endmodule

// File: tb/tb_unified_program_mem.sv
// Bench for unified_program_mem: directed corner cases plus randomized traffic against a byte-level memory model.
module tb_unified_program_mem;
    parameter int RL = 1;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        imem_req_in, imem_stall_in, imem_valid_out;
    logic [31:0] imem_addr_in, imem_data_out;
    logic        dmem_req_in, dmem_we_in, dmem_unsigned_in, dmem_rvalid_out;
    logic [1:0]  dmem_size_in;
    logic [31:0] dmem_addr_in, dmem_wdata_in, dmem_rdata_out;
`ifdef UNIFIED_PROGRAM_MEM_FAULT_EN
    logic        dmem_fault_out;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] mb [int];

    unified_program_mem #(.READ_LATENCY(RL)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .imem_req_in(imem_req_in), .imem_addr_in(imem_addr_in), .imem_stall_in(imem_stall_in),
        .imem_valid_out(imem_valid_out), .imem_data_out(imem_data_out),
        .dmem_req_in(dmem_req_in), .dmem_we_in(dmem_we_in), .dmem_size_in(dmem_size_in),
        .dmem_unsigned_in(dmem_unsigned_in), .dmem_addr_in(dmem_addr_in), .dmem_wdata_in(dmem_wdata_in),
        .dmem_rvalid_out(dmem_rvalid_out), .dmem_rdata_out(dmem_rdata_out)
`ifdef UNIFIED_PROGRAM_MEM_FAULT_EN
        , .dmem_fault_out(dmem_fault_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    function automatic bit in_win(input logic [31:0] a);
        return (a & 32'h000F_0000) == 32'h0002_0000;
    endfunction

    function automatic bit misal(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int base;
        if (!in_win(a) || misal(a, sz)) return;
        base = int'(a[15:0]);
        for (int i = 0; i < nbytes(sz); i++) mb[base + i] = wd[8*i +: 8];
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        int n;
        int base;
        logic [31:0] v;
        if (!in_win(a) || misal(a, sz)) return 32'h0;
        n = nbytes(sz);
        base = int'(a[15:0]);
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] fetch_exp(input logic [31:0] a);
        int base;
        if (!in_win(a)) return NOP;
        base = int'(a[15:0]) & ~3;
        return {mb[base + 3], mb[base + 2], mb[base + 1], mb[base]};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_d(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] wd);
        dmem_req_in = 1'b1; dmem_we_in = we; dmem_size_in = sz;
        dmem_unsigned_in = uns; dmem_addr_in = a; dmem_wdata_in = wd;
    endtask

    task automatic clr_d();
        dmem_req_in = 1'b0; dmem_we_in = 1'b0;
    endtask

    task automatic do_access(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                             input logic [31:0] wd, output logic rv, output logic [31:0] rd, output logic flt);
        set_d(we, sz, uns, a, wd);
        tick();
        clr_d();
        repeat (RL - 1) tick();
        rv = dmem_rvalid_out;
        rd = dmem_rdata_out;
`ifdef UNIFIED_PROGRAM_MEM_FAULT_EN
        flt = dmem_fault_out;
`else
        flt = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        imem_req_in = 1'b0; imem_stall_in = 1'b0; imem_addr_in = '0;
        dmem_req_in = 1'b0; dmem_we_in = 1'b0; dmem_size_in = 2'd2; dmem_unsigned_in = 1'b0;
        dmem_addr_in = '0; dmem_wdata_in = '0;
        repeat (3) tick();
        checks++; if (imem_valid_out !== 1'b0) begin errors++; $display("FAIL reset_imem_valid got=%b exp=0", imem_valid_out); end
        checks++; if (imem_data_out !== 32'h0) begin errors++; $display("FAIL reset_imem_data got=%h exp=0", imem_data_out); end
        checks++; if (dmem_rvalid_out !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", dmem_rvalid_out); end
        checks++; if (dmem_rdata_out !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", dmem_rdata_out); end
`ifdef UNIFIED_PROGRAM_MEM_FAULT_EN
        checks++; if (dmem_fault_out !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", dmem_fault_out); end
`endif
        rst_n_in = 1'b1;
        tick();
    endtask

    task automatic test_word();
        logic rv, flt; logic [31:0] rd;
        do_access(1'b1, 2'd2, 1'b0, 32'h0002_0010, 32'hDEAD_BEEF, rv, rd, flt);
        checks++; if (rv !== 1'b0) begin errors++; $display("FAIL store_no_response rvalid=%b exp=0", rv); end
        do_access(1'b0, 2'd2, 1'b0, 32'h0002_0010, 32'h0, rv, rd, flt);
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL word_load_rvalid got=%b exp=1", rv); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_load_data got=%h exp=deadbeef", rd); end
        tick();
        checks++; if (dmem_rvalid_out !== 1'b0) begin errors++; $display("FAIL rvalid_single_pulse got=%b exp=0", dmem_rvalid_out); end
    endtask

    task automatic test_byte();
        logic rv, flt; logic [31:0] rd;
        do_access(1'b1, 2'd0, 1'b0, 32'h0002_0013, 32'h0000_00AA, rv, rd, flt);
        do_access(1'b0, 2'd0, 1'b0, 32'h0002_0013, 32'h0, rv, rd, flt);
        checks++; if (rd !== 32'hFFFF_FFAA) begin errors++; $display("FAIL byte_signed got=%h exp=ffffffaa", rd); end
        do_access(1'b0, 2'd0, 1'b1, 32'h0002_0013, 32'h0, rv, rd, flt);
        checks++; if (rd !== 32'h0000_00AA) begin errors++; $display("FAIL byte_unsigned got=%h exp=000000aa", rd); end
        do_access(1'b0, 2'd2, 1'b0, 32'h0002_0010, 32'h0, rv, rd, flt);
        checks++; if (rd !== 32'hAAAD_BEEF) begin errors++; $display("FAIL byte_merge_word got=%h exp=aaadbeef", rd); end
    endtask

    task automatic test_oow();
        logic rv, flt; logic [31:0] rd;
        do_access(1'b1, 2'd2, 1'b0, 32'h0003_0010, 32'h1234_5678, rv, rd, flt);
`ifdef UNIFIED_PROGRAM_MEM_FAULT_EN
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL oow_store_fault got=%b exp=1", flt); end
`endif
        do_access(1'b0, 2'd2, 1'b0, 32'h0002_0010, 32'h0, rv, rd, flt);
        checks++; if (rd !== 32'hAAAD_BEEF) begin errors++; $display("FAIL oow_store_no_write got=%h exp=aaadbeef", rd); end
        do_access(1'b0, 2'd2, 1'b0, 32'h0003_0010, 32'h0, rv, rd, flt);
        checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oow_load got rv=%b data=%h exp rv=1 data=0", rv, rd); end
`ifdef UNIFIED_PROGRAM_MEM_FAULT_EN
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL oow_load_fault got=%b exp=1", flt); end
`endif
    endtask

    task automatic test_misaligned();
        logic rv, flt; logic [31:0] rd;
        do_access(1'b1, 2'd1, 1'b0, 32'h0002_0011, 32'h0000_5555, rv, rd, flt);
`ifdef UNIFIED_PROGRAM_MEM_FAULT_EN
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL misaligned_store_fault got=%b exp=1", flt); end
`endif
        do_access(1'b1, 2'd1, 1'b0, 32'h0002_0012, 32'h0000_1234, rv, rd, flt);
`ifdef UNIFIED_PROGRAM_MEM_FAULT_EN
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL aligned_store_fault got=%b exp=0", flt); end
`endif
        do_access(1'b0, 2'd2, 1'b0, 32'h0002_0010, 32'h0, rv, rd, flt);
        checks++; if (rd !== 32'h1234_BEEF) begin errors++; $display("FAIL misaligned_then_store got=%h exp=1234beef", rd); end
        do_access(1'b0, 2'd2, 1'b0, 32'h0002_0012, 32'h0, rv, rd, flt);
        checks++; if (rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_load got rv=%b data=%h exp rv=1 data=0", rv, rd); end
`ifdef UNIFIED_PROGRAM_MEM_FAULT_EN
        checks++; if (flt !== 1'b1) begin errors++; $display("FAIL misaligned_load_fault got=%b exp=1", flt); end
`endif
    endtask

    task automatic test_random();
        localparam int N = 300;
        logic        ev [N + 2];
        logic        ef [N + 2];
        logic [31:0] ed [N + 2];
        for (int i = 0; i < N + 2; i++) begin ev[i] = 1'b0; ef[i] = 1'b0; ed[i] = '0; end
        for (int k = 0; k < N; k++) begin
            logic req, we, uns;
            logic [1:0] sz;
            logic [31:0] a, wd;
            wd = $urandom;
            if (k < 16) begin
                req = 1'b1; we = 1'b1; sz = 2'd2; uns = 1'b0; a = 32'h0002_0100 + 32'(4 * k);
            end else begin
                req = ($urandom_range(0, 9) >= 2);
                we  = 1'($urandom_range(0, 1));
                sz  = 2'($urandom_range(0, 3));
                uns = 1'($urandom_range(0, 1));
                a   = 32'h0002_0100 + 32'($urandom_range(0, 63));
                if ($urandom_range(0, 9) == 0) a = a + 32'h0001_0000;
            end
            if (req) begin
                ef[k + RL - 1] = !in_win(a) || misal(a, sz);
                if (!we) begin
                    ev[k + RL - 1] = 1'b1;
                    ed[k + RL - 1] = model_load(a, sz, uns);
                end else begin
                    model_store(a, sz, wd);
                end
                set_d(we, sz, uns, a, wd);
            end else begin
                clr_d();
            end
            tick();
            checks++; if (dmem_rvalid_out !== ev[k]) begin errors++; $display("FAIL rand_rvalid cyc=%0d got=%b exp=%b", k, dmem_rvalid_out, ev[k]); end
            if (ev[k]) begin
                checks++; if (dmem_rdata_out !== ed[k]) begin errors++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", k, dmem_rdata_out, ed[k]); end
            end
`ifdef UNIFIED_PROGRAM_MEM_FAULT_EN
            checks++; if (dmem_fault_out !== ef[k]) begin errors++; $display("FAIL rand_fault cyc=%0d got=%b exp=%b", k, dmem_fault_out, ef[k]); end
`endif
        end
        clr_d();
        for (int k = N; k < N + RL - 1; k++) begin
            tick();
            checks++; if (dmem_rvalid_out !== ev[k] || (ev[k] && dmem_rdata_out !== ed[k]))
                begin errors++; $display("FAIL rand_drain cyc=%0d got rv=%b data=%h exp rv=%b data=%h", k, dmem_rvalid_out, dmem_rdata_out, ev[k], ed[k]); end
        end
    endtask

    task automatic test_fetch_stall();
        logic rv, flt; logic [31:0] rd;
        logic        hv [$];
        logic [31:0] hd [$];
        logic        s_rq [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        s_st [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] s_ad [9] = '{32'h0002_0000, 32'h0002_0104, 32'h0002_0104, 32'h0002_0104,
                                  32'h0002_0104, 32'h0002_0108, 32'h0003_0000, 32'h0, 32'h0};
        do_access(1'b1, 2'd2, 1'b0, 32'h0002_0000, 32'hCAFE_0001, rv, rd, flt);
        model_store(32'h0002_0000, 2'd2, 32'hCAFE_0001);
        for (int c = 0; c < 60; c++) begin
            logic rq, st, exp_v;
            logic [31:0] ad, exp_d;
            if (c < 9) begin
                rq = s_rq[c]; st = s_st[c]; ad = s_ad[c];
            end else begin
                st = ($urandom_range(0, 3) == 0);
                rq = ($urandom_range(0, 3) != 0);
                ad = 32'h0002_0100 + 32'($urandom_range(0, 63));
                if ($urandom_range(0, 7) == 0) ad = 32'h0003_0000 | 32'($urandom_range(0, 255));
                if ($urandom_range(0, 7) == 0) ad = 32'h0002_0002;
            end
            imem_req_in = rq; imem_stall_in = st; imem_addr_in = ad;
            tick();
            if (!st) begin
                hv.push_back(rq);
                hd.push_back(rq ? fetch_exp(ad) : 32'h0);
            end
            exp_v = (hv.size() >= RL) ? hv[hv.size() - RL] : 1'b0;
            exp_d = (hv.size() >= RL) ? hd[hd.size() - RL] : 32'h0;
            checks++; if (imem_valid_out !== exp_v) begin errors++; $display("FAIL fetch_valid cyc=%0d got=%b exp=%b", c, imem_valid_out, exp_v); end
            if (exp_v) begin
                checks++; if (imem_data_out !== exp_d) begin errors++; $display("FAIL fetch_data cyc=%0d got=%h exp=%h", c, imem_data_out, exp_d); end
            end
        end
        imem_req_in = 1'b0; imem_stall_in = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        logic rv, flt; logic [31:0] rd;
        do_access(1'b1, 2'd2, 1'b0, 32'h0002_0020, 32'h1111_1111, rv, rd, flt);
        imem_req_in = 1'b1; imem_stall_in = 1'b0; imem_addr_in = 32'h0002_0020;
        set_d(1'b1, 2'd2, 1'b0, 32'h0002_0020, 32'h2222_2222);
        tick();
        imem_req_in = 1'b0;
        clr_d();
        repeat (RL - 1) tick();
        checks++; if (imem_valid_out !== 1'b1 || imem_data_out !== 32'h1111_1111)
            begin errors++; $display("FAIL collision_fetch_old got v=%b data=%h exp v=1 data=11111111", imem_valid_out, imem_data_out); end
        do_access(1'b0, 2'd2, 1'b0, 32'h0002_0020, 32'h0, rv, rd, flt);
        checks++; if (rd !== 32'h2222_2222) begin errors++; $display("FAIL collision_store_new got=%h exp=22222222", rd); end
    endtask

    task automatic test_reset_inflight();
        logic rv, flt; logic [31:0] rd;
        set_d(1'b0, 2'd2, 1'b0, 32'h0002_0010, 32'h0);
        tick();
        set_d(1'b0, 2'd2, 1'b0, 32'h0002_0014, 32'h0);
        tick();
        #2 rst_n_in = 1'b0;
        #1;
        checks++; if (dmem_rvalid_out !== 1'b0 || dmem_rdata_out !== 32'h0)
            begin errors++; $display("FAIL async_reset_dmem got rv=%b data=%h exp 0/0", dmem_rvalid_out, dmem_rdata_out); end
        checks++; if (imem_valid_out !== 1'b0 || imem_data_out !== 32'h0)
            begin errors++; $display("FAIL async_reset_imem got v=%b data=%h exp 0/0", imem_valid_out, imem_data_out); end
`ifdef UNIFIED_PROGRAM_MEM_FAULT_EN
        checks++; if (dmem_fault_out !== 1'b0) begin errors++; $display("FAIL async_reset_fault got=%b exp=0", dmem_fault_out); end
`endif
        set_d(1'b1, 2'd2, 1'b0, 32'h0002_0010, 32'hFFFF_FFFF);
        imem_req_in = 1'b1; imem_addr_in = 32'h0002_0000;
        repeat (3) tick();
        clr_d();
        imem_req_in = 1'b0;
        rst_n_in = 1'b1;
        for (int c = 0; c < RL + 1; c++) begin
            tick();
            checks++; if (dmem_rvalid_out !== 1'b0 || imem_valid_out !== 1'b0)
                begin errors++; $display("FAIL post_reset_quiet cyc=%0d got rv=%b iv=%b exp 0/0", c, dmem_rvalid_out, imem_valid_out); end
        end
        do_access(1'b0, 2'd2, 1'b0, 32'h0002_0010, 32'h0, rv, rd, flt);
        checks++; if (rv !== 1'b1 || rd !== 32'h1234_BEEF)
            begin errors++; $display("FAIL mem_intact_after_reset got rv=%b data=%h exp 1/1234beef", rv, rd); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_oow();
        test_misaligned();
        test_random();
        test_fetch_stall();
        test_collision();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
